// File: rtl/bemf_adc_responder.sv
// bemf_adc_responder: emulated 4-bit-command / 13-bit-result serial ADC.
// BEMF_ADC_RESP_FRAMECHK_EN enables start-bit rejection and ErrCount.
module bemf_adc_responder (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic        SClk,
  input  logic        CsN,
  input  logic        Sdi,
  output logic        Sdo,
  output logic        SdoEn,
  output logic [3:0]  ChanSel,
  output logic        ChanReq,
  input  logic [12:0] ChanData,
  output logic        FrameDone,
  output logic        FrameErr,
  output logic [7:0]  ErrCount
);

  typedef enum logic [2:0] {
    IDLE, START, ADDR, TURN, DATA, HOLD
  } state_t;

  state_t state, stateNext;

  logic [1:0]  sclkSync, csnSync, sdiSync;
  logic        sclkD, sRise, sFall;
  logic        csHigh, sdiS, armed;
  logic [2:0]  cmd;
  logic [1:0]  bitCnt;
  logic        turnCnt;
  logic [3:0]  idx;
  logic [12:0] shift;
  logic        sdoReg;
  logic        decodeHit, doneHit, errHit;
  logic        startBad, inFrame;

  assign csHigh = csnSync[1];
  assign sdiS   = sdiSync[1];

  // CsN sync resets low so a CsN already low at release is not a new frame
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      sclkSync <= 2'b00;
      csnSync  <= 2'b00;
      sdiSync  <= 2'b00;
      sclkD    <= 1'b0;
      sRise    <= 1'b0;
      sFall    <= 1'b0;
      armed    <= 1'b0;
    end else begin
      sclkSync <= {sclkSync[0], SClk};
      csnSync  <= {csnSync[0], CsN};
      sdiSync  <= {sdiSync[0], Sdi};
      sclkD    <= sclkSync[1];
      sRise    <= sclkSync[1] & ~sclkD;
      sFall    <= ~sclkSync[1] & sclkD;
      if (csHigh)
        armed <= 1'b1;
    end
  end

`ifdef BEMF_ADC_RESP_FRAMECHK_EN
  assign startBad = ~sdiS;
`else
  assign startBad = 1'b0;
`endif

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)
      state <= IDLE;
    else
      state <= stateNext;
  end

  assign inFrame = (state == START) || (state == ADDR) ||
                   (state == TURN)  || (state == DATA);

  always_comb begin
    stateNext = state;
    decodeHit = 1'b0;
    doneHit   = 1'b0;
    errHit    = 1'b0;
    if (inFrame && csHigh) begin
      stateNext = IDLE;
      errHit    = 1'b1;
    end else begin
      unique case (state)
        IDLE:
          if (!csHigh)
            stateNext = armed ? START : HOLD;
        START:
          if (sRise) begin
            stateNext = startBad ? HOLD : ADDR;
            errHit    = startBad;
          end
        ADDR:
          if (sRise && bitCnt == 2'd0) begin
            stateNext = TURN;
            decodeHit = 1'b1;
          end
        TURN:
          if (sRise && turnCnt)
            stateNext = DATA;
        DATA:
          if (sRise && idx == 4'd0) begin
            stateNext = HOLD;
            doneHit   = 1'b1;
          end
        HOLD:
          if (csHigh)
            stateNext = IDLE;
        default:
          stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    SdoEn = (state == DATA);
    Sdo   = SdoEn & sdoReg;
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      cmd       <= 3'd0;
      bitCnt    <= 2'd0;
      turnCnt   <= 1'b0;
      idx       <= 4'd0;
      shift     <= 13'd0;
      sdoReg    <= 1'b0;
      ChanSel   <= 4'd0;
      ChanReq   <= 1'b0;
      FrameDone <= 1'b0;
      FrameErr  <= 1'b0;
    end else begin
      ChanReq   <= decodeHit;
      FrameDone <= doneHit;
      FrameErr  <= errHit;
      if (ChanReq)
        shift <= ChanData;
      if (state == START && sRise)
        bitCnt <= 2'd3;
      if (state == ADDR && sRise) begin
        cmd    <= {cmd[1:0], sdiS};
        bitCnt <= bitCnt - 2'd1;
      end
      if (decodeHit) begin
        ChanSel <= {cmd, sdiS};
        turnCnt <= 1'b0;
      end
      if (state == TURN && sRise) begin
        turnCnt <= 1'b1;
        idx     <= 4'd12;
        sdoReg  <= 1'b0;
      end
      if (state == DATA && sFall)
        sdoReg <= shift[idx];
      if (state == DATA && sRise && idx != 4'd0)
        idx <= idx - 4'd1;
    end
  end

`ifdef BEMF_ADC_RESP_FRAMECHK_EN
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)
      ErrCount <= 8'h00;
    else if (errHit && ErrCount != 8'hFF)
      ErrCount <= ErrCount + 8'd1;
  end
`else
  assign ErrCount = 8'h00;
`endif

endmodule

// File: tb/tb_bemf_adc_responder.sv
// tb_bemf_adc_responder: directed initiator bench for the serial ADC responder.
// Build with BEMF_ADC_RESP_FRAMECHK_EN to exercise the start-bit checks.
module tb_bemf_adc_responder;

  localparam int HALF = 41;

  logic        Clk;
  logic        ResetN;
  logic        SClk;
  logic        CsN;
  logic        Sdi;
  logic        Sdo;
  logic        SdoEn;
  logic [3:0]  ChanSel;
  logic        ChanReq;
  logic [12:0] ChanData;
  logic        FrameDone;
  logic        FrameErr;
  logic [7:0]  ErrCount;

  logic [12:0] chanMem [16];
  int checks = 0;
  int errors = 0;
  int reqCnt = 0;
  int doneCnt = 0;
  int errCnt = 0;
  logic sawEn;

  bemf_adc_responder dut (
    .Clk(Clk), .ResetN(ResetN), .SClk(SClk), .CsN(CsN),
    .Sdi(Sdi), .Sdo(Sdo), .SdoEn(SdoEn), .ChanSel(ChanSel),
    .ChanReq(ChanReq), .ChanData(ChanData),
    .FrameDone(FrameDone), .FrameErr(FrameErr),
    .ErrCount(ErrCount)
  );

  assign ChanData = chanMem[ChanSel];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(negedge Clk) begin
    if (ChanReq) reqCnt++;
    if (FrameDone) doneCnt++;
    if (FrameErr) errCnt++;
  end

  task automatic waitClk(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (SdoEn) sawEn = 1'b1;
    end
  endtask

  task automatic sendBit(input logic b);
    Sdi = b;
    waitClk(HALF);
    SClk = 1'b1;
  endtask

  task automatic fallEdge();
    waitClk(HALF);
    SClk = 1'b0;
  endtask

  // leaves SClk high after the last requested rise
  task automatic runFrame(input logic startBit, input logic [3:0] cmd,
                          input int rises, output logic [12:0] got);
    logic b;
    got = 13'd0;
    CsN = 1'b0;
    waitClk(8);
    for (int k = 0; k < rises; k++) begin
      if (k == 0) b = startBit;
      else if (k < 5) b = cmd[4-k];
      else b = 1'b0;
      sendBit(b);
      if (k >= 7) got = {got[11:0], Sdo};
      if (k < rises - 1) fallEdge();
    end
  endtask

  task automatic endFrame();
    SClk = 1'b0;
    CsN = 1'b1;
    waitClk(10);
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    SClk = 1'b0;
    CsN = 1'b1;
    Sdi = 1'b0;
    waitClk(4);
    checks += 7;
    if (Sdo !== 1'b0) begin errors++;
      $display("FAIL rst_sdo got %b want 0", Sdo); end
    if (SdoEn !== 1'b0) begin errors++;
      $display("FAIL rst_sdoen got %b want 0", SdoEn); end
    if (ChanSel !== 4'd0) begin errors++;
      $display("FAIL rst_chansel got %h want 0", ChanSel); end
    if (ChanReq !== 1'b0) begin errors++;
      $display("FAIL rst_chanreq got %b want 0", ChanReq); end
    if (FrameDone !== 1'b0) begin errors++;
      $display("FAIL rst_done got %b want 0", FrameDone); end
    if (FrameErr !== 1'b0) begin errors++;
      $display("FAIL rst_err got %b want 0", FrameErr); end
    if (ErrCount !== 8'h00) begin errors++;
      $display("FAIL rst_errcount got %h want 00", ErrCount); end
    ResetN = 1'b1;
    waitClk(10);
  endtask

  task automatic test_nominal();
    logic [12:0] got;
    int r0, d0, e0;
    chanMem[6] = 13'h0A5B;
    r0 = reqCnt; d0 = doneCnt; e0 = errCnt;
    runFrame(1'b1, 4'b0110, 20, got);
    waitClk(HALF);
    checks += 6;
    if (SdoEn !== 1'b0) begin errors++;
      $display("FAIL nom_sdoen_end got %b want 0", SdoEn); end
    endFrame();
    if (got !== 13'h0A5B) begin errors++;
      $display("FAIL nom_data got %h want 0a5b", got); end
    if (ChanSel !== 4'd6) begin errors++;
      $display("FAIL nom_chansel got %h want 6", ChanSel); end
    if (reqCnt - r0 !== 1) begin errors++;
      $display("FAIL nom_req got %0d want 1", reqCnt - r0); end
    if (doneCnt - d0 !== 1) begin errors++;
      $display("FAIL nom_done got %0d want 1", doneCnt - d0); end
    if (errCnt - e0 !== 0) begin errors++;
      $display("FAIL nom_err got %0d want 0", errCnt - e0); end
  endtask

  task automatic test_start_zero();
    logic [12:0] got;
    int d0, e0, r0;
    chanMem[5] = 13'h0F0F;
    r0 = reqCnt; d0 = doneCnt; e0 = errCnt;
    sawEn = 1'b0;
    runFrame(1'b0, 4'd5, 20, got);
    waitClk(HALF);
    endFrame();
`ifdef BEMF_ADC_RESP_FRAMECHK_EN
    checks += 4;
    if (sawEn !== 1'b0) begin errors++;
      $display("FAIL sz_noen got %b want 0", sawEn); end
    if (errCnt - e0 !== 1) begin errors++;
      $display("FAIL sz_err got %0d want 1", errCnt - e0); end
    if (ErrCount !== 8'd1) begin errors++;
      $display("FAIL sz_errcount got %h want 01", ErrCount); end
    if (reqCnt - r0 !== 0) begin errors++;
      $display("FAIL sz_req got %0d want 0", reqCnt - r0); end
`else
    checks += 4;
    if (got !== 13'h0F0F) begin errors++;
      $display("FAIL sz_data got %h want 0f0f", got); end
    if (doneCnt - d0 !== 1) begin errors++;
      $display("FAIL sz_done got %0d want 1", doneCnt - d0); end
    if (errCnt - e0 !== 0) begin errors++;
      $display("FAIL sz_err got %0d want 0", errCnt - e0); end
    if (reqCnt - r0 !== 1) begin errors++;
      $display("FAIL sz_req got %0d want 1", reqCnt - r0); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [3:0]  cmds [4];
    logic [12:0] vals [4];
    logic [12:0] got;
    cmds = '{4'd0, 4'd2, 4'd4, 4'd6};
    vals = '{13'h1FFF, 13'h0000, 13'h1555, 13'h0AAA};
    for (int i = 0; i < 4; i++) chanMem[cmds[i]] = vals[i];
    for (int i = 0; i < 4; i++) begin
      runFrame(1'b1, cmds[i], 20, got);
      waitClk(HALF);
      endFrame();
      checks += 2;
      if (got !== vals[i]) begin errors++;
        $display("FAIL b2b_data[%0d] got %h want %h", i, got, vals[i]); end
      if (ChanSel !== cmds[i]) begin errors++;
        $display("FAIL b2b_chansel[%0d] got %h want %h",
                 i, ChanSel, cmds[i]); end
    end
  endtask

  task automatic test_abort();
    logic [12:0] got;
    int d0, e0;
    chanMem[3] = 13'h1234;
    d0 = doneCnt; e0 = errCnt;
    runFrame(1'b1, 4'd3, 16, got);
    waitClk(4);
    CsN = 1'b1;
    waitClk(3);
    checks += 5;
    if (SdoEn !== 1'b0) begin errors++;
      $display("FAIL ab_sdoen got %b want 0", SdoEn); end
    waitClk(3);
    if (errCnt - e0 !== 1) begin errors++;
      $display("FAIL ab_err got %0d want 1", errCnt - e0); end
    if (doneCnt - d0 !== 0) begin errors++;
      $display("FAIL ab_done got %0d want 0", doneCnt - d0); end
    if (got !== 13'h0123) begin errors++;
      $display("FAIL ab_partial got %h want 0123", got); end
    if (ChanSel !== 4'd3) begin errors++;
      $display("FAIL ab_chansel got %h want 3", ChanSel); end
    SClk = 1'b0;
    waitClk(10);
    runFrame(1'b1, 4'd3, 20, got);
    waitClk(HALF);
    endFrame();
    checks += 1;
    if (got !== 13'h1234) begin errors++;
      $display("FAIL ab_next got %h want 1234", got); end
  endtask

  task automatic test_reset_mid();
    logic [12:0] got;
    int r0;
    chanMem[9] = 13'h1ABC;
    runFrame(1'b1, 4'd9, 10, got);
    waitClk(2);
    ResetN = 1'b0;
    #1;
    checks += 5;
    if (SdoEn !== 1'b0) begin errors++;
      $display("FAIL mr_sdoen got %b want 0", SdoEn); end
    if (Sdo !== 1'b0) begin errors++;
      $display("FAIL mr_sdo got %b want 0", Sdo); end
    if (ChanSel !== 4'd0) begin errors++;
      $display("FAIL mr_chansel got %h want 0", ChanSel); end
    if (ChanReq !== 1'b0) begin errors++;
      $display("FAIL mr_chanreq got %b want 0", ChanReq); end
    if (ErrCount !== 8'h00) begin errors++;
      $display("FAIL mr_errcount got %h want 00", ErrCount); end
    waitClk(3);
    ResetN = 1'b1;
    r0 = reqCnt;
    sawEn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      fallEdge();
      sendBit(1'b1);
    end
    checks += 2;
    if (sawEn !== 1'b0) begin errors++;
      $display("FAIL mr_nodrive got %b want 0", sawEn); end
    if (reqCnt - r0 !== 0) begin errors++;
      $display("FAIL mr_noreq got %0d want 0", reqCnt - r0); end
    endFrame();
    runFrame(1'b1, 4'd9, 20, got);
    waitClk(HALF);
    endFrame();
    checks += 1;
    if (got !== 13'h1ABC) begin errors++;
      $display("FAIL mr_next got %h want 1abc", got); end
  endtask

  task automatic test_saturate();
`ifdef BEMF_ADC_RESP_FRAMECHK_EN
    for (int i = 0; i < 300; i++) begin
      CsN = 1'b0;
      waitClk(8);
      sendBit(1'b0);
      waitClk(6);
      CsN = 1'b1;
      waitClk(6);
      SClk = 1'b0;
      waitClk(4);
    end
    checks += 1;
    if (ErrCount !== 8'hFF) begin errors++;
      $display("FAIL sat_errcount got %h want ff", ErrCount); end
`else
    checks += 1;
    if (ErrCount !== 8'h00) begin errors++;
      $display("FAIL sat_errcount got %h want 00", ErrCount); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 16; i++) chanMem[i] = 13'd0;
    sawEn = 1'b0;
    test_reset();
    test_nominal();
    test_start_zero();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bemf_adc_responder.md
# bemf_adc_responder

Serial-ADC responder: the device end of the 4-bit-command / 13-bit-result serial exchange issued by the BEMF controller's ADC front end. It decodes the chip-select-framed start bit and 4-bit channel command, fetches a 13-bit conversion result from a per-channel source, and shifts it back MSB first on the shared data line. It serves as an FPGA-emulated ADC for loopback test builds and as the bus-functional device in the BEMF controller bench.

## Interface
- No parameters.
- Clk  in  1  system clock, same domain as the BEMF controller.
- ResetN  in  1  asynchronous, active-low reset.
- SClk  in  1  serial clock from the initiator (Clk/82 nominal), asynchronous to Clk.
- CsN  in  1  chip select, low during a frame.
- Sdi  in  1  command data from the initiator; changes on SClk fall.
- Sdo  out  1  result data to the initiator; 0 when SdoEn=0.
- SdoEn  out  1  drive enable for the shared data pin.
- ChanSel  out  4  decoded channel command, held until the next decode.
- ChanReq  out  1  one-Clk pulse when ChanSel is updated.
- ChanData  in  13  result for ChanSel; captured the Clk after ChanReq.
- FrameDone  out  1  one-Clk pulse after D0 is sampled by the initiator.
- FrameErr  out  1  one-Clk pulse on an aborted or rejected frame.
- ErrCount  out  8  saturating error count (BEMF_ADC_RESP_FRAMECHK_EN only; else tied 0).

## Operation
- SClk, CsN and Sdi each pass through a 2-flop synchronizer. Edge detect on the synchronized SClk yields SRise and SFall, one Clk each.
- States: IDLE, START, ADDR, TURN, DATA, HOLD.
- IDLE: synchronized CsN low -> START.
- START: on SRise, sample Sdi as the start bit, then -> ADDR with BitCnt=3. With the macro, a 0 start bit -> HOLD plus FrameErr.
- ADDR: on each SRise, shift Sdi into Cmd, MSB first. On the SRise with BitCnt=0, set ChanSel to the full 4-bit Cmd, pulse ChanReq, and go to TURN with TurnCnt=0. On the next Clk, Shift[12:0] <= ChanData.
- TURN: absorbs the 2 initiator turnaround rises. On the 2nd SRise -> DATA with Idx=12.
- DATA: SdoEn=1. On each SFall, Sdo <= Shift[Idx]. On each SRise, the initiator samples: if Idx=0, SdoEn <= 0, pulse FrameDone, and go to HOLD; otherwise Idx <= Idx-1.
- HOLD: synchronized CsN high -> IDLE. SdoEn=0.
- Frame length: 20 SClk rises (1 start, 4 command, 2 turnaround, 13 data).
- Sdo=0 whenever SdoEn=0.

## Timing
- Reset values: Sdo=0, SdoEn=0, ChanSel=0, ChanReq=0, FrameDone=0, FrameErr=0, ErrCount=0, state IDLE.
- Edge latency: 3 Clk from a pin edge to SRise/SFall. Sdo is updated 4 Clk after the SClk pin falls, well inside the 41-Clk half period.
- ChanData must be stable from the Clk after ChanReq until the capture edge. No wait states.
- CsN high in START, ADDR, TURN or DATA: -> IDLE next Clk, SdoEn=0, FrameErr pulse. Shift contents and ChanSel are retained.
- CsN high in HOLD is a normal end of frame: no error.
- SRise and a CsN deassert on the same Clk: the abort wins.
- ResetN low mid-frame: immediate return to IDLE with SdoEn=0. After release, the next frame starts only on a new CsN fall; a CsN that is already low waits in HOLD for CsN high.

## Configuration
- BEMF_ADC_RESP_FRAMECHK_EN defined:
  - Start bit is checked; a 0 start bit rejects the frame to HOLD with FrameErr, and Sdo is never driven.
  - ErrCount increments, saturating at 8'hFF, on every FrameErr.
- Undefined:
  - Start bit is ignored and the frame always proceeds.
  - ErrCount is constant 0.
  - Aborts still pulse FrameErr.

## Test plan
- Nominal frame: start=1, Cmd=4'b0110, ChanData=13'h0A5B -> ChanSel=6 with one ChanReq pulse; initiator samples 13'h0A5B; one FrameDone pulse; SdoEn low before the 21st SClk fall.
- Back-to-back frames on Cmd 0, 2, 4, 6 with ChanData = 13'h1FFF, 0, 13'h1555, 13'h0AAA -> each value returned exactly; ChanSel tracks each Cmd.
- CsN raised after the 9th data rise -> FrameErr pulse, SdoEn=0 within 3 Clk; the next full frame returns correct data.
- Start bit 0: with the macro, no SdoEn, FrameErr=1, ErrCount=1; without it, a normal frame completes.
- ResetN asserted during DATA -> all outputs at reset values immediately; CsN held low produces no drive until CsN toggles high then low.
- 300 start-bit errors with the macro -> ErrCount saturates at 8'hFF.
